// File: rtl/dispatch_stage.sv
// dispatch_stage: one-entry dispatch buffer that resolves operands from the regfile/CDB, renames rd and hands off to RS or LSB
// Ports: clk/rst/rdy/flush control; in_* decoded instruction with in_valid/in_ready handshake;
// rs*_to_reg/*_from_reg regfile read; rd_*_to_reg/rd_wr_en rename; cdb_* broadcast snoop;
// rs_ready/lsb_ready downstream space; out_valid_rs/out_valid_ls and out_* held instruction.
module dispatch_stage #(
  parameter int ROB_W = 4,
  parameter int CDB_N = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     rdy,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [ROB_W-1:0]         in_entry,
  input  logic [31:0]              in_pc,
  input  logic [4:0]               in_rd,
  input  logic [4:0]               in_rs1,
  input  logic [4:0]               in_rs2,
  input  logic [31:0]              in_imm,
  input  logic [5:0]               in_op,
  input  logic                     in_is_ls,
  output logic [4:0]               rs1_to_reg,
  output logic [4:0]               rs2_to_reg,
  output logic [4:0]               rd_to_reg,
  output logic [ROB_W-1:0]         rd_tag_to_reg,
  output logic                     rd_wr_en,
  input  logic [31:0]              Vj_from_reg,
  input  logic [31:0]              Vk_from_reg,
  input  logic                     Qj_busy_from_reg,
  input  logic                     Qk_busy_from_reg,
  input  logic [ROB_W-1:0]         Qj_from_reg,
  input  logic [ROB_W-1:0]         Qk_from_reg,
  input  logic [CDB_N-1:0]         cdb_valid,
  input  logic [CDB_N*ROB_W-1:0]   cdb_tag,
  input  logic [CDB_N*32-1:0]      cdb_value,
  input  logic                     rs_ready,
  input  logic                     lsb_ready,
  output logic                     out_valid_rs,
  output logic                     out_valid_ls,
  output logic [ROB_W-1:0]         out_entry,
  output logic [31:0]              out_pc,
  output logic [4:0]               out_rd,
  output logic [31:0]              out_imm,
  output logic [5:0]               out_op,
  output logic [31:0]              out_Vj,
  output logic [31:0]              out_Vk,
  output logic                     out_Qj_busy,
  output logic                     out_Qk_busy,
  output logic [ROB_W-1:0]         out_Qj,
  output logic [ROB_W-1:0]         out_Qk
);
  logic hv_q, hv_d, is_ls_q, is_ls_d, bj_q, bj_d, bk_q, bk_d;
  logic [ROB_W-1:0] entry_q, entry_d, qj_q, qj_d, qk_q, qk_d;
  logic [31:0] pc_q, pc_d, imm_q, imm_d, vj_q, vj_d, vk_q, vk_d;
  logic [4:0] rd_q, rd_d;
  logic [5:0] op_q, op_d;
  logic drain, capture;
  logic [32:0] cap_j, cap_k, snp_j, snp_k;
  // {hit, value}; scanning downward lets the lowest-index matching channel win
  function automatic logic [32:0] cdb_hit(input logic [ROB_W-1:0] tag, input logic [CDB_N-1:0] v,
                                          input logic [CDB_N*ROB_W-1:0] t, input logic [CDB_N*32-1:0] d);
    logic [32:0] r;
    r = '0;
    for (int i = CDB_N - 1; i >= 0; i--)
      if (v[i] && t[i*ROB_W +: ROB_W] == tag) r = {1'b1, d[i*32 +: 32]};
    return r;
  endfunction
  assign out_valid_rs  = hv_q & ~is_ls_q;
  assign out_valid_ls  = hv_q & is_ls_q;
  assign drain         = (out_valid_rs & rs_ready) | (out_valid_ls & lsb_ready);
  assign in_ready      = rdy & ~flush & ~rst & (~hv_q | drain);
  assign capture       = in_valid & in_ready;
  assign rd_wr_en      = capture & (|in_rd);
  assign rs1_to_reg    = in_rs1;
  assign rs2_to_reg    = in_rs2;
  assign rd_to_reg     = in_rd;
  assign rd_tag_to_reg = in_entry;
  assign out_entry     = entry_q;
  assign out_pc        = pc_q;
  assign out_rd        = rd_q;
  assign out_imm       = imm_q;
  assign out_op        = op_q;
  assign out_Vj        = vj_q;
  assign out_Vk        = vk_q;
  assign out_Qj_busy   = bj_q;
  assign out_Qk_busy   = bk_q;
  assign out_Qj        = qj_q;
  assign out_Qk        = qk_q;
  always_comb begin
    cap_j   = cdb_hit(Qj_from_reg, cdb_valid, cdb_tag, cdb_value);
    cap_k   = cdb_hit(Qk_from_reg, cdb_valid, cdb_tag, cdb_value);
    snp_j   = cdb_hit(qj_q, cdb_valid, cdb_tag, cdb_value);
    snp_k   = cdb_hit(qk_q, cdb_valid, cdb_tag, cdb_value);
    hv_d    = flush ? 1'b0 : capture ? 1'b1 : drain ? 1'b0 : hv_q;
    entry_d = capture ? in_entry : entry_q;
    pc_d    = capture ? in_pc : pc_q;
    rd_d    = capture ? in_rd : rd_q;
    imm_d   = capture ? in_imm : imm_q;
    op_d    = capture ? in_op : op_q;
    is_ls_d = capture ? in_is_ls : is_ls_q;
    vj_d    = capture ? (~|in_rs1 ? 32'd0 : (Qj_busy_from_reg & cap_j[32]) ? cap_j[31:0] : Vj_from_reg)
                      : (hv_q & bj_q & snp_j[32]) ? snp_j[31:0] : vj_q;
    vk_d    = capture ? (~|in_rs2 ? 32'd0 : (Qk_busy_from_reg & cap_k[32]) ? cap_k[31:0] : Vk_from_reg)
                      : (hv_q & bk_q & snp_k[32]) ? snp_k[31:0] : vk_q;
    bj_d    = capture ? (|in_rs1) & Qj_busy_from_reg & ~cap_j[32] : bj_q & ~(hv_q & snp_j[32]);
    bk_d    = capture ? (|in_rs2) & Qk_busy_from_reg & ~cap_k[32] : bk_q & ~(hv_q & snp_k[32]);
    qj_d    = capture ? (~|in_rs1 ? '0 : Qj_from_reg) : qj_q;
    qk_d    = capture ? (~|in_rs2 ? '0 : Qk_from_reg) : qk_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      {hv_q, is_ls_q, bj_q, bk_q, entry_q, qj_q, qk_q, pc_q, imm_q, vj_q, vk_q, rd_q, op_q} <= '0;
    end else if (rdy) begin
      hv_q    <= hv_d;
      is_ls_q <= is_ls_d;
      bj_q    <= bj_d;
      bk_q    <= bk_d;
      entry_q <= entry_d;
      qj_q    <= qj_d;
      qk_q    <= qk_d;
      pc_q    <= pc_d;
      imm_q   <= imm_d;
      vj_q    <= vj_d;
      vk_q    <= vk_d;
      rd_q    <= rd_d;
      op_q    <= op_d;
    end
  end
endmodule

// File: tb/tb_dispatch_stage.sv
// tb_dispatch_stage: directed scenarios plus randomized traffic against a behavioural model of dispatch_stage
module tb_dispatch_stage;
  localparam int RW = 4;
  localparam int CN = 2;
  logic clk = 1'b0;
  logic rst, rdy, flush, in_valid, in_ready, in_is_ls, rd_wr_en;
  logic Qj_busy_from_reg, Qk_busy_from_reg, rs_ready, lsb_ready;
  logic out_valid_rs, out_valid_ls, out_Qj_busy, out_Qk_busy;
  logic [RW-1:0] in_entry, rd_tag_to_reg, Qj_from_reg, Qk_from_reg, out_entry, out_Qj, out_Qk;
  logic [31:0] in_pc, in_imm, Vj_from_reg, Vk_from_reg, out_pc, out_imm, out_Vj, out_Vk;
  logic [4:0] in_rd, in_rs1, in_rs2, rs1_to_reg, rs2_to_reg, rd_to_reg, out_rd;
  logic [5:0] in_op, out_op;
  logic [CN-1:0] cdb_valid;
  logic [CN*RW-1:0] cdb_tag;
  logic [CN*32-1:0] cdb_value;
  int n_chk = 0;
  int n_pass = 0;
  typedef struct packed {
    logic v;
    logic [RW-1:0] entry;
    logic [31:0] pc;
    logic [4:0] rd;
    logic [31:0] imm;
    logic [5:0] op;
    logic ls;
    logic [31:0] vj, vk;
    logic bj, bk;
    logic [RW-1:0] qj, qk;
  } held_t;
  always #5 clk = ~clk;
  dispatch_stage #(.ROB_W(RW), .CDB_N(CN)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_entry(in_entry), .in_pc(in_pc),
    .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm), .in_op(in_op), .in_is_ls(in_is_ls),
    .rs1_to_reg(rs1_to_reg), .rs2_to_reg(rs2_to_reg), .rd_to_reg(rd_to_reg),
    .rd_tag_to_reg(rd_tag_to_reg), .rd_wr_en(rd_wr_en),
    .Vj_from_reg(Vj_from_reg), .Vk_from_reg(Vk_from_reg),
    .Qj_busy_from_reg(Qj_busy_from_reg), .Qk_busy_from_reg(Qk_busy_from_reg),
    .Qj_from_reg(Qj_from_reg), .Qk_from_reg(Qk_from_reg),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
    .rs_ready(rs_ready), .lsb_ready(lsb_ready),
    .out_valid_rs(out_valid_rs), .out_valid_ls(out_valid_ls),
    .out_entry(out_entry), .out_pc(out_pc), .out_rd(out_rd), .out_imm(out_imm), .out_op(out_op),
    .out_Vj(out_Vj), .out_Vk(out_Vk), .out_Qj_busy(out_Qj_busy), .out_Qk_busy(out_Qk_busy),
    .out_Qj(out_Qj), .out_Qk(out_Qk)
  );
  task automatic idle();
    rst = 1'b0; rdy = 1'b1; flush = 1'b0; in_valid = 1'b0; in_entry = '0; in_pc = '0;
    in_rd = '0; in_rs1 = '0; in_rs2 = '0; in_imm = '0; in_op = '0; in_is_ls = 1'b0;
    Vj_from_reg = '0; Vk_from_reg = '0; Qj_busy_from_reg = 1'b0; Qk_busy_from_reg = 1'b0;
    Qj_from_reg = '0; Qk_from_reg = '0; cdb_valid = '0; cdb_tag = '0; cdb_value = '0;
    rs_ready = 1'b0; lsb_ready = 1'b0;
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  function automatic logic [32:0] bus_find(input logic [RW-1:0] t);
    for (int i = 0; i < CN; i++)
      if (cdb_valid[i] && cdb_tag[i*RW +: RW] == t) return {1'b1, cdb_value[i*32 +: 32]};
    return '0;
  endfunction
  function automatic logic [32+RW:0] resolve(input logic [4:0] idx, input logic [31:0] v,
                                              input logic b, input logic [RW-1:0] q);
    logic [32:0] f;
    if (idx == 5'd0) return '0;
    f = bus_find(q);
    if (b && f[32]) return {f[31:0], 1'b0, q};
    return {v, b, q};
  endfunction
  function automatic logic drains(input held_t h);
    return h.v && (h.ls ? lsb_ready : rs_ready);
  endfunction
  function automatic logic exp_ready(input held_t h);
    return !rst && rdy && !flush && (!h.v || drains(h));
  endfunction
  function automatic held_t model_next(input held_t h);
    held_t n;
    logic [32:0] f;
    logic acc;
    n = h;
    if (rst) return '0;
    if (!rdy) return h;
    acc = exp_ready(h) && in_valid;
    if (h.v && h.bj) begin f = bus_find(h.qj); if (f[32]) begin n.vj = f[31:0]; n.bj = 1'b0; end end
    if (h.v && h.bk) begin f = bus_find(h.qk); if (f[32]) begin n.vk = f[31:0]; n.bk = 1'b0; end end
    if (flush || drains(h)) n.v = 1'b0;
    if (acc) begin
      n.v = 1'b1; n.entry = in_entry; n.pc = in_pc; n.rd = in_rd; n.imm = in_imm; n.op = in_op; n.ls = in_is_ls;
      {n.vj, n.bj, n.qj} = resolve(in_rs1, Vj_from_reg, Qj_busy_from_reg, Qj_from_reg);
      {n.vk, n.bk, n.qk} = resolve(in_rs2, Vk_from_reg, Qk_busy_from_reg, Qk_from_reg);
    end
    return n;
  endfunction
  task automatic test_reset();
    idle(); rst = 1'b1; in_valid = 1'b1; in_rd = 5'd3; #1;
    n_chk++; if (in_ready !== 1'b0) $display("FAIL rst_in_ready got %b exp 0", in_ready); else n_pass++;
    n_chk++; if (rd_wr_en !== 1'b0) $display("FAIL rst_wr_en got %b exp 0", rd_wr_en); else n_pass++;
    tick();
    n_chk++; if ({out_valid_rs, out_valid_ls} !== 2'b00) $display("FAIL rst_valid got %b exp 00", {out_valid_rs, out_valid_ls}); else n_pass++;
    n_chk++; if ({out_Vj, out_Vk, out_Qj_busy, out_Qk_busy, out_Qj, out_Qk, out_pc, out_entry, out_imm, out_op, out_rd} !== '0)
      $display("FAIL rst_fields got Vj=%h Vk=%h bj=%b bk=%b pc=%h exp all 0", out_Vj, out_Vk, out_Qj_busy, out_Qk_busy, out_pc); else n_pass++;
    rst = 1'b0; in_valid = 1'b0; #1;
    n_chk++; if (in_ready !== 1'b1) $display("FAIL rst_release_ready got %b exp 1", in_ready); else n_pass++;
  endtask
  task automatic test_back_to_back();
    idle(); in_valid = 1'b1; in_entry = 4'd1; in_rd = 5'd3; in_pc = 32'h100; rs_ready = 1'b1; #1;
    n_chk++; if ({rd_wr_en, rd_tag_to_reg, rd_to_reg} !== {1'b1, 4'd1, 5'd3}) $display("FAIL b2b_renameA got %b/%0d/%0d exp 1/1/3", rd_wr_en, rd_tag_to_reg, rd_to_reg); else n_pass++;
    tick();
    in_entry = 4'd2; in_rd = 5'd4; in_pc = 32'h104; #1;
    n_chk++; if ({out_valid_rs, out_entry} !== {1'b1, 4'd1}) $display("FAIL b2b_heldA got %b/%0d exp 1/1", out_valid_rs, out_entry); else n_pass++;
    n_chk++; if ({in_ready, rd_wr_en, rd_tag_to_reg} !== {1'b1, 1'b1, 4'd2}) $display("FAIL b2b_renameB got %b/%b/%0d exp 1/1/2", in_ready, rd_wr_en, rd_tag_to_reg); else n_pass++;
    tick();
    in_valid = 1'b0;
    n_chk++; if ({out_valid_rs, out_entry, out_pc} !== {1'b1, 4'd2, 32'h104}) $display("FAIL b2b_heldB got %b/%0d/%h exp 1/2/104", out_valid_rs, out_entry, out_pc); else n_pass++;
    tick();
    n_chk++; if (out_valid_rs !== 1'b0) $display("FAIL b2b_drained got %b exp 0", out_valid_rs); else n_pass++;
  endtask
  task automatic test_bypass();
    idle(); rs_ready = 1'b1; in_valid = 1'b1; in_entry = 4'd3; in_rd = 5'd6;
    in_rs1 = 5'd1; Qj_busy_from_reg = 1'b1; Qj_from_reg = 4'd5; Vj_from_reg = 32'h1111;
    in_rs2 = 5'd0; Qk_busy_from_reg = 1'b1; Qk_from_reg = 4'd5; Vk_from_reg = 32'h2222;
    cdb_valid = 2'b10; cdb_tag = {4'd5, 4'd0}; cdb_value = {32'hDEADBEEF, 32'h0};
    tick();
    n_chk++; if ({out_Vj, out_Qj_busy} !== {32'hDEADBEEF, 1'b0}) $display("FAIL bypass_j got %h/%b exp deadbeef/0", out_Vj, out_Qj_busy); else n_pass++;
    n_chk++; if ({out_Vk, out_Qk_busy} !== {32'h0, 1'b0}) $display("FAIL bypass_x0 got %h/%b exp 0/0", out_Vk, out_Qk_busy); else n_pass++;
    in_rs2 = 5'd2; cdb_valid = 2'b11; cdb_tag = {4'd5, 4'd5}; cdb_value = {32'hBBBB, 32'hAAAA};
    tick();
    n_chk++; if ({out_Vj, out_Vk, out_Qj_busy, out_Qk_busy} !== {32'hAAAA, 32'hAAAA, 2'b00}) $display("FAIL bypass_lowest got %h/%h/%b%b exp aaaa/aaaa/00", out_Vj, out_Vk, out_Qj_busy, out_Qk_busy); else n_pass++;
    Qk_busy_from_reg = 1'b0; Qk_from_reg = 4'd4; cdb_valid = 2'b01; cdb_tag = {4'd0, 4'd4};
    tick();
    n_chk++; if ({out_Qj_busy, out_Qj} !== {1'b1, 4'd5}) $display("FAIL bypass_miss got %b/%0d exp 1/5", out_Qj_busy, out_Qj); else n_pass++;
    n_chk++; if ({out_Vk, out_Qk_busy} !== {32'h2222, 1'b0}) $display("FAIL bypass_notbusy got %h/%b exp 2222/0", out_Vk, out_Qk_busy); else n_pass++;
    in_valid = 1'b0; cdb_valid = '0;
    tick();
  endtask
  task automatic test_snoop();
    idle(); in_valid = 1'b1; in_is_ls = 1'b1; in_entry = 4'd4; in_rd = 5'd7; in_rs2 = 5'd2;
    Qk_busy_from_reg = 1'b1; Qk_from_reg = 4'd7; rs_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (3) tick();
    n_chk++; if ({out_valid_ls, out_valid_rs, out_Qk_busy, out_Qk} !== {3'b101, 4'd7}) $display("FAIL snoop_wait got %b%b%b/%0d exp 101/7", out_valid_ls, out_valid_rs, out_Qk_busy, out_Qk); else n_pass++;
    cdb_valid = 2'b01; cdb_tag = {4'd0, 4'd7}; cdb_value = {32'h0, 32'h10};
    tick();
    cdb_valid = '0;
    n_chk++; if ({out_Vk, out_Qk_busy, out_valid_ls} !== {32'h10, 1'b0, 1'b1}) $display("FAIL snoop_take got %h/%b/%b exp 10/0/1", out_Vk, out_Qk_busy, out_valid_ls); else n_pass++;
    lsb_ready = 1'b1; #1;
    n_chk++; if (in_ready !== 1'b1) $display("FAIL snoop_ready got %b exp 1", in_ready); else n_pass++;
    tick();
    lsb_ready = 1'b0;
    n_chk++; if (out_valid_ls !== 1'b0) $display("FAIL snoop_drain got %b exp 0", out_valid_ls); else n_pass++;
  endtask
  task automatic test_stall_flush();
    idle(); in_valid = 1'b1; in_entry = 4'd5; in_rd = 5'd8;
    tick();
    in_entry = 4'd6; in_rd = 5'd9; #1;
    n_chk++; if ({in_ready, rd_wr_en} !== 2'b00) $display("FAIL stall_ready got %b%b exp 00", in_ready, rd_wr_en); else n_pass++;
    tick();
    n_chk++; if ({out_valid_rs, out_entry} !== {1'b1, 4'd5}) $display("FAIL stall_hold got %b/%0d exp 1/5", out_valid_rs, out_entry); else n_pass++;
    flush = 1'b1; rs_ready = 1'b1; #1;
    n_chk++; if ({in_ready, rd_wr_en} !== 2'b00) $display("FAIL flush_rename got %b%b exp 00", in_ready, rd_wr_en); else n_pass++;
    tick();
    flush = 1'b0; in_valid = 1'b0; rs_ready = 1'b0;
    n_chk++; if (out_valid_rs !== 1'b0) $display("FAIL flush_clear got %b exp 0", out_valid_rs); else n_pass++;
  endtask
  task automatic test_rdy_reset();
    idle(); in_valid = 1'b1; in_entry = 4'd2; in_rd = 5'd1; in_rs1 = 5'd3; Qj_busy_from_reg = 1'b1; Qj_from_reg = 4'd2;
    tick();
    Qj_busy_from_reg = 1'b0; rdy = 1'b0; in_entry = 4'd9; rs_ready = 1'b1;
    cdb_valid = 2'b01; cdb_tag = {4'd0, 4'd2}; cdb_value = {32'h0, 32'h55}; #1;
    n_chk++; if ({in_ready, rd_wr_en} !== 2'b00) $display("FAIL rdy_gate got %b%b exp 00", in_ready, rd_wr_en); else n_pass++;
    tick();
    n_chk++; if ({out_valid_rs, out_entry, out_Qj_busy} !== {1'b1, 4'd2, 1'b1}) $display("FAIL rdy_freeze got %b/%0d/%b exp 1/2/1", out_valid_rs, out_entry, out_Qj_busy); else n_pass++;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_chk++; if ({out_valid_rs, out_valid_ls, out_Qj_busy, out_entry, out_Qj} !== '0) $display("FAIL rst_midhold got %b%b%b/%0d/%0d exp all 0", out_valid_rs, out_valid_ls, out_Qj_busy, out_entry, out_Qj); else n_pass++;
    rdy = 1'b1; cdb_valid = '0; in_rd = 5'd0; in_entry = 4'd3; rs_ready = 1'b0; #1;
    n_chk++; if ({in_ready, rd_wr_en} !== 2'b10) $display("FAIL rd0_rename got %b%b exp 10", in_ready, rd_wr_en); else n_pass++;
    tick();
    in_valid = 1'b0; rs_ready = 1'b1;
    n_chk++; if ({out_valid_rs, out_entry, out_rd} !== {1'b1, 4'd3, 5'd0}) $display("FAIL rd0_held got %b/%0d/%0d exp 1/3/0", out_valid_rs, out_entry, out_rd); else n_pass++;
    tick();
  endtask
  task automatic test_random();
    held_t m, nx;
    logic er;
    idle(); rst = 1'b1;
    tick();
    m = '0;
    for (int c = 0; c < 600; c++) begin
      rst = ($urandom_range(49, 0) == 0); rdy = ($urandom_range(9, 0) != 0); flush = ($urandom_range(19, 0) == 0);
      in_valid = ($urandom_range(3, 0) != 0); in_entry = RW'($urandom_range(15, 0)); in_pc = $urandom();
      in_rd = 5'($urandom_range(3, 0)); in_rs1 = 5'($urandom_range(3, 0)); in_rs2 = 5'($urandom_range(3, 0));
      in_imm = $urandom(); in_op = 6'($urandom_range(63, 0)); in_is_ls = 1'($urandom_range(1, 0));
      Vj_from_reg = $urandom(); Vk_from_reg = $urandom();
      Qj_busy_from_reg = 1'($urandom_range(1, 0)); Qk_busy_from_reg = 1'($urandom_range(1, 0));
      Qj_from_reg = RW'($urandom_range(3, 0)); Qk_from_reg = RW'($urandom_range(3, 0));
      cdb_valid = CN'($urandom_range(3, 0));
      for (int i = 0; i < CN; i++) cdb_tag[i*RW +: RW] = RW'($urandom_range(3, 0));
      cdb_value = {$urandom(), $urandom()};
      rs_ready = 1'($urandom_range(1, 0)); lsb_ready = 1'($urandom_range(1, 0));
      #1;
      er = exp_ready(m);
      n_chk++; if (in_ready !== er) $display("FAIL rnd_in_ready c=%0d got %b exp %b", c, in_ready, er); else n_pass++;
      n_chk++; if (rd_wr_en !== (er & in_valid & (in_rd != 5'd0))) $display("FAIL rnd_wr_en c=%0d got %b exp %b", c, rd_wr_en, er & in_valid & (in_rd != 5'd0)); else n_pass++;
      n_chk++; if ({rs1_to_reg, rs2_to_reg, rd_to_reg, rd_tag_to_reg} !== {in_rs1, in_rs2, in_rd, in_entry}) $display("FAIL rnd_regidx c=%0d got %0d/%0d/%0d/%0d", c, rs1_to_reg, rs2_to_reg, rd_to_reg, rd_tag_to_reg); else n_pass++;
      nx = model_next(m);
      @(posedge clk);
      #1;
      m = nx;
      n_chk++; if ({out_valid_rs, out_valid_ls} !== {m.v & !m.ls, m.v & m.ls}) $display("FAIL rnd_valid c=%0d got %b%b exp %b%b", c, out_valid_rs, out_valid_ls, m.v & !m.ls, m.v & m.ls); else n_pass++;
      if (m.v) begin
        n_chk++; if ({out_entry, out_pc, out_rd, out_imm, out_op} !== {m.entry, m.pc, m.rd, m.imm, m.op}) $display("FAIL rnd_fields c=%0d got %0d/%h/%0d/%h/%0d exp %0d/%h/%0d/%h/%0d", c, out_entry, out_pc, out_rd, out_imm, out_op, m.entry, m.pc, m.rd, m.imm, m.op); else n_pass++;
        n_chk++; if ({out_Vj, out_Qj_busy} !== {m.vj, m.bj} || (m.bj && out_Qj !== m.qj)) $display("FAIL rnd_opj c=%0d got %h/%b/%0d exp %h/%b/%0d", c, out_Vj, out_Qj_busy, out_Qj, m.vj, m.bj, m.qj); else n_pass++;
        n_chk++; if ({out_Vk, out_Qk_busy} !== {m.vk, m.bk} || (m.bk && out_Qk !== m.qk)) $display("FAIL rnd_opk c=%0d got %h/%b/%0d exp %h/%b/%0d", c, out_Vk, out_Qk_busy, out_Qk, m.vk, m.bk, m.qk); else n_pass++;
      end
    end
  endtask
  initial begin
    idle();
    test_reset();
    test_back_to_back();
    test_bypass();
    test_snoop();
    test_stall_flush();
    test_rdy_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/dispatch_stage.md
DISPATCH_STAGE -- requirements
Module: dispatch_stage

Interface
REQ-001 SHALL provide parameter ROB_W, default 4: ROB entry tag width.
REQ-002 SHALL provide parameter CDB_N, default 2: number of common-data-bus broadcast channels.
REQ-003 SHALL use one clock; reset is synchronous and active-high.
REQ-004 SHALL provide these ports (name  direction  width  meaning):
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- rdy  in  1  global enable; low freezes the block
- flush  in  1  mispredict clear
- in_valid  in  1  decoded instruction present
- in_ready  out  1  stage accepts an instruction this cycle
- in_entry  in  ROB_W  allocated ROB tag
- in_pc  in  32  instruction PC
- in_rd, in_rs1, in_rs2  in  5 each  register indices
- in_imm  in  32  immediate
- in_op  in  6  opcode
- in_is_ls  in  1  load/store (LSB) vs ALU (RS)
- rs1_to_reg, rs2_to_reg  out  5 each  regfile read indices, combinational from in_rs1/in_rs2
- rd_to_reg  out  5  rename index
- rd_tag_to_reg  out  ROB_W  rename tag
- rd_wr_en  out  1  rename strobe
- Vj_from_reg, Vk_from_reg  in  32 each  regfile values
- Qj_busy_from_reg, Qk_busy_from_reg  in  1 each  operand pending
- Qj_from_reg, Qk_from_reg  in  ROB_W each  producer tags
- cdb_valid  in  CDB_N  per-channel broadcast valid
- cdb_tag  in  CDB_N*ROB_W  packed tags; channel i at [i*ROB_W +: ROB_W]
- cdb_value  in  CDB_N*32  packed results
- rs_ready, lsb_ready  in  1 each  downstream has a free slot
- out_valid_rs, out_valid_ls  out  1 each  held instruction targets RS / LSB
- out_entry, out_pc, out_rd, out_imm, out_op  out  as inputs  held fields
- out_Vj, out_Vk  out  32 each; out_Qj_busy, out_Qk_busy  out  1 each; out_Qj, out_Qk  out  ROB_W each

Function
REQ-005 SHALL hold exactly one instruction in an output register; hv denotes its valid bit.
REQ-006 SHALL drive out_valid_rs = hv & !held_is_ls and out_valid_ls = hv & held_is_ls.
REQ-007 SHALL define drain = (out_valid_rs & rs_ready) | (out_valid_ls & lsb_ready); the downstream consumes the instruction on any cycle in which drain is high and rdy is high.
REQ-008 SHALL drive in_ready = rdy & !flush & (!hv | drain) combinationally.
REQ-009 SHALL define capture = in_valid & in_ready; on capture, load all in_* fields and the resolved operands at the clock edge and set hv=1.
REQ-010 SHALL clear hv on drain without capture; SHALL keep hv=1 on simultaneous drain and capture (back-to-back, one instruction per cycle).
REQ-011 SHALL resolve each operand on capture as follows:
- index 0: V=0, busy=0.
- Otherwise, if the regfile busy bit is set and some channel i has cdb_valid[i] with a tag equal to the regfile tag: V=cdb_value of that channel, busy=0.
- Otherwise: V, busy and Q taken from the regfile.
REQ-012 SHALL select the lowest-index matching channel when several CDB channels match the same tag.
REQ-013 SHALL snoop the CDB every cycle while hv=1 without drain: a busy operand whose Q matches a valid channel SHALL take that value and clear busy at the next edge.
REQ-014 SHALL drive rd_wr_en = capture & (in_rd != 0), with rd_to_reg=in_rd and rd_tag_to_reg=in_entry, so that renaming occurs in the same edge as capture.
REQ-015 SHALL clear hv at the next edge on flush=1 (with rdy=1), perform no capture, and hold rd_wr_en=0 regardless of in_valid.
REQ-016 SHALL, while rdy=0, hold all registers, and force in_ready=0 and rd_wr_en=0; snooping SHALL be suspended.
REQ-017 SHALL give flush priority over drain and capture in the same cycle.
REQ-018 SHALL have no combinational path from rs_ready or lsb_ready to any out_* field; in_ready depends on them only through drain.

Reset
REQ-019 SHALL, when rst=1 at a clock edge, regardless of rdy or flush:
- clear hv and all held fields, including V, Q and busy, to 0;
- make out_valid_rs, out_valid_ls, in_ready and rd_wr_en low in the following cycle;
- abort any in-flight instruction with no rename.
REQ-020 SHALL make in_ready high in the first cycle after rst deasserts, provided rdy=1 and flush=0.

Verification
REQ-021 Back-to-back: ALU insts A (rd=3, tag=1) then B; rs_ready=1 -> out_valid_rs high two consecutive cycles; rd_wr_en pulses for both with tags 1 and 2.
REQ-022 Capture-time bypass: rs1 busy with Qj=5; cdb_valid=2'b10, cdb_tag ch1=5, value=0xDEADBEEF -> out_Vj=0xDEADBEEF, out_Qj_busy=0.
REQ-023 Held snoop: LSB inst with Qk busy tag=7, lsb_ready=0; three cycles later ch0 broadcasts tag 7, value 0x10 -> next cycle out_Vk=0x10, busy=0; lsb_ready=1 -> drained, in_ready=1.
REQ-024 Stall/flush: hv=1, rs_ready=0, in_valid=1 -> in_ready=0, no rd_wr_en; then flush=1 -> hv=0 next cycle, no rename.
REQ-025 rdy/reset: rdy=0 with in_valid=1 -> state frozen, no capture; rst mid-hold -> all outputs 0 next cycle; rd=0 inst -> rd_wr_en=0.
